mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter placed in front of the `memory_group` word RAM. It shares the single RAM port between the instruction-fetch requester and the data (load/store) requester. It converts 16-bit byte addresses to 14-bit word addresses and builds the byte write mask and the lane-replicated store data. It also flags misaligned or illegal accesses without touching memory, and returns one response per accepted request.

## Interface
Parameters:
- `ADDR_W`, 16 — byte-address width; `mem_addr` = `ADDR_W-2` bits.

Ports:
- Clocking and reset:
  - `clk` in 1 — single clock for the whole block.
  - `rst` in 1 — reset, asynchronous, active-high.
- Instruction-fetch port:
  - `i_req_valid` in 1 — fetch request.
  - `i_req_ready` out 1 — fetch request accepted this cycle.
  - `i_req_addr` in 16 — fetch byte address.
  - `i_rsp_valid` out 1 — fetch response, one-cycle pulse.
  - `i_rsp_data` out 32 — fetched word.
  - `i_rsp_err` out 1 — misaligned fetch.
- Data port:
  - `d_req_valid` in 1 — data request.
  - `d_req_ready` out 1 — data request accepted.
  - `d_req_addr` in 16 — byte address.
  - `d_req_we` in 1 — 1 = store, 0 = load.
  - `d_req_size` in 2 — 0 = byte, 1 = half, 2 = word, 3 = reserved.
  - `d_req_wdata` in 32 — store data, right-aligned.
  - `d_rsp_valid` out 1 — data response pulse; issued for loads and stores.
  - `d_rsp_data` out 32 — raw loaded word; 0 for stores and errors.
  - `d_rsp_err` out 1 — misaligned or reserved size.
- Memory-side port:
  - `mem_write_mask` out 4 — byte enables to `memory_group`.
  - `mem_addr` out 14 — word address.
  - `mem_write_data` out 32 — lane-replicated store data.
  - `mem_read_data` in 32 — registered read data, valid the cycle after the address edge.

## Operation
- Each cycle, at most one request is granted. Ready is combinational from the valids and the arbitration state, and never depends on the response path.
- Accept means `valid && ready` at a rising edge.
- Memory outputs are driven combinationally from the granted request.
- When nothing is granted, or the granted request errors:
  - `mem_write_mask` = 0.
  - `mem_addr` and `mem_write_data` are don't-care.
- Store alignment (data port):
  - Size 0: mask = `1 << addr[1:0]`; data = byte replicated ×4.
  - Size 1: `addr[0]` must be 0; mask = 4'b0011 or 4'b1100 by `addr[1]`; data = halfword replicated ×2.
  - Size 2: `addr[1:0]` must be 00; mask = 4'b1111.
  - Size 3 or a misalignment is an error: the request is accepted and the mask is forced to 0.
- Loads drive mask 0. A fetch with `addr[1:0]` ≠ 0 is an error, and memory is not written.
- Response registers:
  - `rsp_owner` (none / I / D) and `rsp_err` are captured at accept.
  - In the next cycle, the owner's `*_rsp_valid` is 1 and its `*_rsp_data` = `mem_read_data`. For stores and errors, `*_rsp_data` = 0.
  - Responses have no backpressure; requesters must sink them.
- Arbitration:
  - With a single requester valid, that requester is granted.
  - When both are valid, the policy depends on the `MEM_ARB_RR_EN` macro (see Configuration).

## Timing
- Accept at edge N; response visible from edge N+1 until edge N+2. Load latency is 1 cycle.
- Back-to-back accepts every cycle are allowed, including alternating owners. The response to N and the grant for N+1 coexist in the same cycle.
- Reset values:
  - Both `*_rsp_valid` = 0, `*_rsp_err` = 0, `*_rsp_data` = 0.
  - `rsp_owner` = none and `last_grant` = I.
  - Both ready outputs = 0 while `rst` is high; `mem_write_mask` = 0.
- Reset asserted mid-transaction: a pending response is dropped, and no response follows deassertion.
- Requests held low during reset are not accepted.
- Store and load to the same address in consecutive cycles: the load returns the new data, because the write lands at edge N and the read at edge N+1.

## Configuration
- `MEM_ARB_RR_EN` defined — round-robin:
  - `last_grant` is updated on every grant.
  - On contention, the requester ≠ `last_grant` wins.
  - After reset, D wins the first contention.
- Undefined — fixed priority: D always wins contention, and `last_grant` is unused. I can starve; this is acceptable because the core stalls fetch during loads/stores.

## Structure
- `mem_arb_pkg` contains:
  - Size enum: `SZ_B`, `SZ_H`, `SZ_W`.
  - Owner enum: `OWN_NONE`, `OWN_I`, `OWN_D`.
  - `WORD_OFS` = 2.
- Sub-module `mem_store_align`: purely combinational. Inputs are addr[1:0], size, we, and wdata; outputs are mask, replicated data, and err. It is instantiated once.
- Arbitration, response registers, and muxing live in `mem_arbiter`.

## Test plan
- Store word: D store 0x77FF8855 to byte addr 0x0004, size 2 → mask 1111, `mem_addr` 0x0001. Next cycle, `d_rsp_valid`=1 with `d_rsp_err`=0. A load of 0x0004 then returns 0x77FF8855.
- Store byte: D store byte 0xAB to addr 0x0006 over 0x77FF8855 → mask 0100, `mem_write_data` 0xABABABAB. A later load of 0x0004 returns 0x77AB8855.
- Contention: I and D both valid for 4 cycles.
  - With `MEM_ARB_RR_EN`: grants D, I, D, I.
  - Without it: D ×4 and `i_req_ready`=0 throughout.
- Errors:
  - D half store at addr 0x0003 → mask 0000, `d_rsp_err`=1 next cycle, memory unchanged.
  - Fetch at 0x0002 → `i_rsp_err`=1.
- Reset mid-transaction: assert `rst` one cycle after a load accept → `d_rsp_valid` stays 0, with no response after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned WORD_OFS = 2;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MASK_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // Response state captured at accept: who owns the next-cycle response,
  // whether it errored and whether it returns read data.
  typedef struct packed {
    owner_e owner;
    logic   err;
    logic   rd;
  } rsp_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, response and memory-side signals of the memory arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
);
  localparam int unsigned MA_W = ADDR_W - WORD_OFS;

  logic                i_req_valid;
  logic                i_req_ready;
  logic [ADDR_W-1:0]   i_req_addr;
  logic                i_rsp_valid;
  logic [DATA_W-1:0]   i_rsp_data;
  logic                i_rsp_err;

  logic                d_req_valid;
  logic                d_req_ready;
  logic [ADDR_W-1:0]   d_req_addr;
  logic                d_req_we;
  logic [1:0]          d_req_size;
  logic [DATA_W-1:0]   d_req_wdata;
  logic                d_rsp_valid;
  logic [DATA_W-1:0]   d_rsp_data;
  logic                d_rsp_err;

  logic [MASK_W-1:0]   mem_write_mask;
  logic [MA_W-1:0]     mem_addr;
  logic [DATA_W-1:0]   mem_write_data;
  logic [DATA_W-1:0]   mem_read_data;

  modport slave (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_addr, d_req_we, d_req_size, d_req_wdata,
    input  mem_read_data,
    output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_write_mask, mem_addr, mem_write_data
  );

  modport master (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_addr, d_req_we, d_req_size, d_req_wdata,
    output mem_read_data,
    input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_write_mask, mem_addr, mem_write_data
  );

endinterface

// File: rtl/mem_store_align.sv
// Data-port alignment check, byte-enable generation and store-lane replication.
module mem_store_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]        i_addr_lo,
  input  logic [1:0]        i_size,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [MASK_W-1:0] o_mask_c,
  output logic [DATA_W-1:0] o_wdata_c,
  output logic              o_err_c
);

  logic [MASK_W-1:0] w_mask;

  always_comb begin
    w_mask    = '0;
    o_wdata_c = i_wdata;
    o_err_c   = 1'b0;
    case (size_e'(i_size))
      SZ_B: begin
        w_mask    = MASK_W'(1) << i_addr_lo;
        o_wdata_c = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_err_c   = i_addr_lo[0];
        w_mask    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_c = {2{i_wdata[15:0]}};
      end
      SZ_W: begin
        o_err_c = |i_addr_lo;
        w_mask  = 4'b1111;
      end
      default: o_err_c = 1'b1;
    endcase
    // Loads and faulting accesses must never write memory.
    o_mask_c = (i_we && !o_err_c) ? w_mask : '0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one word-RAM port between instruction fetch and data load/store.
// Define MEM_ARB_RR_EN for round-robin contention; default is data-port priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
)(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  logic              w_i_gnt;
  logic              w_d_gnt;
  logic              w_d_wins;
  logic              w_i_err;
  logic [MASK_W-1:0] w_al_mask;
  logic [DATA_W-1:0] w_al_data;
  logic              w_al_err;
  rsp_t              w_rsp_nxt;
  rsp_t              r_rsp;
  logic              w_i_own;
  logic              w_d_own;

  mem_store_align u_align (
    .i_addr_lo (bus.d_req_addr[1:0]),
    .i_size    (bus.d_req_size),
    .i_we      (bus.d_req_we),
    .i_wdata   (bus.d_req_wdata),
    .o_mask_c  (w_al_mask),
    .o_wdata_c (w_al_data),
    .o_err_c   (w_al_err)
  );

`ifdef MEM_ARB_RR_EN
  owner_e r_last_grant;

  // Contention goes to whichever requester was not granted last.
  assign w_d_wins = (r_last_grant == OWN_I);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= OWN_I;
    end else if (w_d_gnt) begin
      r_last_grant <= OWN_D;
    end else if (w_i_gnt) begin
      r_last_grant <= OWN_I;
    end
  end
`else
  assign w_d_wins = 1'b1;
`endif

  // Grants are held off during reset so nothing is accepted while rst is high.
  assign w_d_gnt = !rst && bus.d_req_valid && (!bus.i_req_valid || w_d_wins);
  assign w_i_gnt = !rst && bus.i_req_valid && (!bus.d_req_valid || !w_d_wins);
  assign w_i_err = |bus.i_req_addr[1:0];

  assign bus.i_req_ready    = w_i_gnt;
  assign bus.d_req_ready    = w_d_gnt;
  assign bus.mem_write_mask = w_d_gnt ? w_al_mask : '0;
  assign bus.mem_write_data = w_al_data;
  assign bus.mem_addr       = w_d_gnt ? bus.d_req_addr[ADDR_W-1:WORD_OFS]
                                      : bus.i_req_addr[ADDR_W-1:WORD_OFS];

  always_comb begin
    w_rsp_nxt = '{owner: OWN_NONE, err: 1'b0, rd: 1'b0};
    if (w_d_gnt) begin
      w_rsp_nxt = '{owner: OWN_D, err: w_al_err, rd: !bus.d_req_we};
    end else if (w_i_gnt) begin
      w_rsp_nxt = '{owner: OWN_I, err: w_i_err, rd: 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp <= '{owner: OWN_NONE, err: 1'b0, rd: 1'b0};
    end else begin
      r_rsp <= w_rsp_nxt;
    end
  end

  // Read data arrives from the RAM register; zero it for stores and errors.
  assign w_i_own         = (r_rsp.owner == OWN_I);
  assign w_d_own         = (r_rsp.owner == OWN_D);
  assign bus.i_rsp_valid = w_i_own;
  assign bus.d_rsp_valid = w_d_own;
  assign bus.i_rsp_err   = w_i_own && r_rsp.err;
  assign bus.d_rsp_err   = w_d_own && r_rsp.err;
  assign bus.i_rsp_data  = (w_i_own && r_rsp.rd && !r_rsp.err) ? bus.mem_read_data : '0;
  assign bus.d_rsp_data  = (w_d_own && r_rsp.rd && !r_rsp.err) ? bus.mem_read_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus response scoreboard.
module tb_mem_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        iv;
    logic [15:0] ia;
    logic        dv;
    logic [15:0] da;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] wd;
    logic        e_ir;
    logic        e_dr;
    logic [3:0]  e_mask;
    logic        chk_addr;
    logic [13:0] e_maddr;
    logic [31:0] e_wd;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic        own_d;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mem_arbiter_if #(.ADDR_W(16)) bus ();

  mem_arbiter #(.ADDR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] ram [0:16383];
  bit   [31:0] shadow [0:16383];
  exp_t        sbq [$];
  vec_t        tbl [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word RAM with registered read, cleared while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16384; i++) ram[i] <= '0;
      bus.mem_read_data <= '0;
    end else begin
      bus.mem_read_data <= ram[bus.mem_addr];
      for (int b = 0; b < 4; b++)
        if (bus.mem_write_mask[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_write_data[8*b +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic iv, logic [15:0] ia, logic dv, logic [15:0] da,
                               logic we, logic [1:0] sz, logic [31:0] wd,
                               logic eir, logic edr, logic [3:0] emask, logic chk_a,
                               logic [13:0] ema, logic [31:0] ewd, logic eerr);
    vec_t v;
    v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.we = we; v.sz = sz; v.wd = wd;
    v.e_ir = eir; v.e_dr = edr; v.e_mask = emask; v.chk_addr = chk_a;
    v.e_maddr = ema; v.e_wd = ewd; v.e_err = eerr;
    return v;
  endfunction

  task automatic drive_idle();
    bus.i_req_valid = 1'b0; bus.i_req_addr = '0;
    bus.d_req_valid = 1'b0; bus.d_req_addr = '0; bus.d_req_we = 1'b0;
    bus.d_req_size  = 2'd0; bus.d_req_wdata = '0;
  endtask

  // Compare this cycle's responses against the oldest scoreboard entry.
  task automatic check_rsp(input string tag);
    exp_t e;
    logic ev_i, ev_d;
    ev_i = 1'b0; ev_d = 1'b0; e.own_d = 1'b0; e.err = 1'b0; e.data = '0;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      ev_d = e.own_d;
      ev_i = !e.own_d;
    end
    chk({tag, " i_rsp_valid"}, 32'(bus.i_rsp_valid), 32'(ev_i));
    chk({tag, " d_rsp_valid"}, 32'(bus.d_rsp_valid), 32'(ev_d));
    chk({tag, " i_rsp_err"},   32'(bus.i_rsp_err),   32'(ev_i && e.err));
    chk({tag, " d_rsp_err"},   32'(bus.d_rsp_err),   32'(ev_d && e.err));
    chk({tag, " i_rsp_data"},  bus.i_rsp_data, ev_i ? e.data : 32'h0);
    chk({tag, " d_rsp_data"},  bus.d_rsp_data, ev_d ? e.data : 32'h0);
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    check_rsp(tag);
    bus.i_req_valid = v.iv; bus.i_req_addr = v.ia;
    bus.d_req_valid = v.dv; bus.d_req_addr = v.da; bus.d_req_we = v.we;
    bus.d_req_size  = v.sz; bus.d_req_wdata = v.wd;
    #1;
    chk({tag, " i_req_ready"}, 32'(bus.i_req_ready), 32'(v.e_ir));
    chk({tag, " d_req_ready"}, 32'(bus.d_req_ready), 32'(v.e_dr));
    chk({tag, " mem_write_mask"}, 32'(bus.mem_write_mask), 32'(v.e_mask));
    if (v.chk_addr) chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(v.e_maddr));
    if (v.e_mask != 4'b0) chk({tag, " mem_write_data"}, bus.mem_write_data, v.e_wd);
    if (v.e_dr) begin
      e.own_d = 1'b1;
      e.err   = v.e_err;
      e.data  = (v.we || v.e_err) ? 32'h0 : shadow[v.e_maddr];
      sbq.push_back(e);
      for (int b = 0; b < 4; b++)
        if (v.e_mask[b]) shadow[v.e_maddr][8*b +: 8] = v.e_wd[8*b +: 8];
    end else if (v.e_ir) begin
      e.own_d = 1'b0;
      e.err   = v.e_err;
      e.data  = v.e_err ? 32'h0 : shadow[v.e_maddr];
      sbq.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " i_req_ready"},    32'(bus.i_req_ready), 32'h0);
    chk({tag, " d_req_ready"},    32'(bus.d_req_ready), 32'h0);
    chk({tag, " mem_write_mask"}, 32'(bus.mem_write_mask), 32'h0);
    chk({tag, " i_rsp_valid"},    32'(bus.i_rsp_valid), 32'h0);
    chk({tag, " d_rsp_valid"},    32'(bus.d_rsp_valid), 32'h0);
    chk({tag, " i_rsp_err"},      32'(bus.i_rsp_err), 32'h0);
    chk({tag, " d_rsp_err"},      32'(bus.d_rsp_err), 32'h0);
    chk({tag, " i_rsp_data"},     bus.i_rsp_data, 32'h0);
    chk({tag, " d_rsp_data"},     bus.d_rsp_data, 32'h0);
  endtask

  vec_t idle_v;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    drive_idle();
    for (int i = 0; i < 16384; i++) shadow[i] = '0;
    idle_v = mkv(0, 16'h0, 0, 16'h0, 0, 2'd0, 32'h0, 0, 0, 4'h0, 0, 14'h0, 32'h0, 0);

    // Contention from reset: round-robin alternates starting with D.
    for (int k = 0; k < 4; k++) begin
      logic ir;
      ir = RR && (k % 2 == 1);
      tbl.push_back(mkv(1, 16'h0010, 1, 16'h0020, 0, 2'd2, 32'h0,
                        ir, !ir, 4'h0, 1, ir ? 14'h0004 : 14'h0008, 32'h0, 0));
    end
    tbl.push_back(mkv(0, 16'h0, 1, 16'h0004, 1, 2'd2, 32'h77FF8855, 0, 1, 4'b1111, 1, 14'h0001, 32'h77FF8855, 0));
    tbl.push_back(mkv(0, 16'h0, 1, 16'h0004, 0, 2'd2, 32'h0,        0, 1, 4'b0000, 1, 14'h0001, 32'h0, 0));
    tbl.push_back(mkv(0, 16'h0, 1, 16'h0006, 1, 2'd0, 32'h000000AB, 0, 1, 4'b0100, 1, 14'h0001, 32'hABABABAB, 0));
    tbl.push_back(mkv(0, 16'h0, 1, 16'h0004, 0, 2'd2, 32'h0,        0, 1, 4'b0000, 1, 14'h0001, 32'h0, 0));
    tbl.push_back(mkv(0, 16'h0, 1, 16'h0003, 1, 2'd1, 32'h00001234, 0, 1, 4'b0000, 0, 14'h0000, 32'h0, 1));
    tbl.push_back(mkv(0, 16'h0, 1, 16'h0004, 0, 2'd2, 32'h0,        0, 1, 4'b0000, 1, 14'h0001, 32'h0, 0));
    tbl.push_back(mkv(1, 16'h0002, 0, 16'h0, 0, 2'd0, 32'h0,        1, 0, 4'b0000, 0, 14'h0000, 32'h0, 1));
    tbl.push_back(mkv(1, 16'h0004, 0, 16'h0, 0, 2'd0, 32'h0,        1, 0, 4'b0000, 1, 14'h0001, 32'h0, 0));
    tbl.push_back(mkv(0, 16'h0, 1, 16'h0002, 1, 2'd1, 32'h0000CAFE, 0, 1, 4'b1100, 1, 14'h0000, 32'hCAFECAFE, 0));
    tbl.push_back(mkv(0, 16'h0, 1, 16'h0000, 0, 2'd3, 32'h0,        0, 1, 4'b0000, 0, 14'h0000, 32'h0, 1));
    tbl.push_back(mkv(0, 16'h0, 1, 16'h0008, 1, 2'd3, 32'hFFFFFFFF, 0, 1, 4'b0000, 0, 14'h0000, 32'h0, 1));
    tbl.push_back(mkv(0, 16'h0, 1, 16'h0000, 0, 2'd2, 32'h0,        0, 1, 4'b0000, 1, 14'h0000, 32'h0, 0));
    tbl.push_back(mkv(1, 16'h0000, 0, 16'h0, 0, 2'd0, 32'h0,        1, 0, 4'b0000, 1, 14'h0000, 32'h0, 0));
    tbl.push_back(mkv(0, 16'h0, 1, 16'h0009, 1, 2'd2, 32'h11111111, 0, 1, 4'b0000, 0, 14'h0000, 32'h0, 1));
    tbl.push_back(mkv(0, 16'h0, 1, 16'h000B, 1, 2'd0, 32'h0000005A, 0, 1, 4'b1000, 1, 14'h0002, 32'h5A5A5A5A, 0));
    tbl.push_back(mkv(0, 16'h0, 1, 16'h0008, 0, 2'd2, 32'h0,        0, 1, 4'b0000, 1, 14'h0002, 32'h0, 0));
    tbl.push_back(idle_v);

    // Reset state, with requests held low.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    foreach (tbl[k]) step(tbl[k], $sformatf("vec%0d", k));
    step(idle_v, "flush");

    // Reset asserted just after a load accept drops its response.
    step(mkv(0, 16'h0, 1, 16'h0004, 0, 2'd2, 32'h0, 0, 1, 4'b0000, 1, 14'h0001, 32'h0, 0), "rst_load");
    @(posedge clk);
    #1;
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.d_req_valid = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    drive_idle();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) step(idle_v, $sformatf("post_reset%0d", k));
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
